// File: rtl/shift_unit_seq_if.sv
// rtl/shift_unit_seq_if.sv - request/response handshake bundle for shift_unit_seq
interface shift_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [31:0]      amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport slave (
    input  in_valid, op, operand, amount, out_ready,
    output in_ready, out_valid, result, ovf
  );

  modport master (
    output in_valid, op, operand, amount, out_ready,
    input  in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle SLL/SRL/SRA shift unit, STEP bits per clock
// Optional rotate-right on op 11 is enabled by defining SHIFT_ROTATE_EN.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_unit_seq_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int SW = $clog2(STEP) + 1;
  localparam logic [SW-1:0] STEP_S   = SW'(STEP);
  localparam logic [LW-1:0] STEP_L   = LW'(STEP);
  localparam logic [31:0]   WIDTH_32 = 32'(WIDTH);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [LW-1:0]    r_rem;
  logic [1:0]       r_op;
  logic             r_sign;
  logic             r_ovf;

  logic             w_idle;
  logic             w_big;
  logic             w_direct;
  logic             w_direct_ovf;
  logic [WIDTH-1:0] w_direct_val;
  logic [WIDTH-1:0] w_src;
  logic [LW-1:0]    w_src_rem;
  logic [1:0]       w_src_op;
  logic             w_src_sign;
  logic [SW-1:0]    w_s;
  logic             w_last;
  logic [WIDTH-1:0] w_stepped;

  // The accept edge already performs the first step, so a shift of n takes ceil(n/STEP) edges.
  assign w_idle     = (r_state == IDLE);
  assign w_src      = w_idle ? bus.operand : r_work;
  assign w_src_rem  = w_idle ? bus.amount[LW-1:0] : r_rem;
  assign w_src_op   = w_idle ? bus.op : r_op;
  assign w_src_sign = w_idle ? bus.operand[WIDTH-1] : r_sign;
  assign w_s        = (w_src_rem < STEP_L) ? w_src_rem[SW-1:0] : STEP_S;
  assign w_last     = (w_src_rem == LW'(w_s));

  assign w_big        = (bus.amount >= WIDTH_32);
  assign w_direct_ovf = (bus.op != OP_ROR) && w_big;
  assign w_direct_val = w_direct_ovf ?
                        ((bus.op == OP_SRA) ? {WIDTH{bus.operand[WIDTH-1]}} : '0) :
                        bus.operand;
`ifdef SHIFT_ROTATE_EN
  assign w_direct = (bus.op == OP_ROR) ? (bus.amount[LW-1:0] == '0)
                                       : (w_big || (bus.amount == '0));
`else
  assign w_direct = (bus.op == OP_ROR) || w_big || (bus.amount == '0);
`endif

  always_comb begin
    w_stepped = w_src;
    case (w_src_op)
      OP_SLL:  w_stepped = w_src << w_s;
      OP_SRL:  w_stepped = w_src >> w_s;
      OP_SRA:  w_stepped = WIDTH'({{WIDTH{w_src_sign}}, w_src} >> w_s);
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  w_stepped = WIDTH'({w_src, w_src} >> w_s);
`endif
      default: w_stepped = w_src;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = (w_direct || w_last) ? DONE : SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_rem  <= '0;
      r_op   <= OP_SLL;
      r_sign <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_idle && bus.in_valid) begin
      r_op   <= bus.op;
      r_sign <= bus.operand[WIDTH-1];
      if (w_direct) begin
        r_work <= w_direct_val;
        r_rem  <= '0;
        r_ovf  <= w_direct_ovf;
      end else begin
        r_work <= w_stepped;
        r_rem  <= w_src_rem - LW'(w_s);
        r_ovf  <= 1'b0;
      end
    end else if (r_state == SHIFT) begin
      r_work <= w_stepped;
      r_rem  <= r_rem - LW'(w_s);
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_work;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - randomized self-checking bench for shift_unit_seq
module tb_shift_unit_seq;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_unit_seq_if #(.WIDTH(WIDTH)) bus ();

  shift_unit_seq #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] x,
                                    input logic [31:0] amt, output logic [31:0] res,
                                    output logic ovf, output int lat);
    int n;
    ovf = 1'b0;
    lat = 1;
    res = x;
    if (op == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
      n = int'(amt % 32);
      if (n != 0) begin
        res = (x >> n) | (x << (32 - n));
        lat = (n + STEP - 1) / STEP;
      end
`endif
    end else if (amt >= 32) begin
      ovf = 1'b1;
      res = (op == 2'b10) ? {32{x[31]}} : 32'h0;
    end else if (amt != 0) begin
      n   = int'(amt);
      lat = (n + STEP - 1) / STEP;
      case (op)
        2'b00:   res = x << n;
        2'b01:   res = x >> n;
        default: res = 32'($signed(x) >>> n);
      endcase
    end
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 with the unit idle again.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] amt, input int hold);
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
    int          cyc;
    logic        busy_ready;
    ref_model(op, x, amt, exp_res, exp_ovf, exp_lat);
    check({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.operand   = x;
    bus.amount    = amt;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.operand  = $urandom;
    bus.amount   = $urandom;
    bus.op       = 2'($urandom_range(0, 3));
    cyc = 1;
    busy_ready = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      busy_ready |= bus.in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_in_ready_busy"}, busy_ready, 0);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    check({tag, "_in_ready_done"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_result"}, bus.result, exp_res);
      check({tag, "_hold_ovf"}, bus.ovf, exp_ovf);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_valid"}, bus.out_valid, 0);
    check({tag, "_release_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_amt;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.operand   = '0;
    bus.amount    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("sll31", 2'b00, 32'h0000_0001, 32'd31, 0);
    run_op("sra32", 2'b10, 32'h8000_0000, 32'd32, 0);
    run_op("srl_big", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("sra5", 2'b10, 32'hF000_0000, 32'd5, 0);
    run_op("sll0", 2'b00, 32'h1234_5678, 32'd0, 0);
    run_op("backpressure", 2'b01, 32'hDEAD_BEEF, 32'd13, 5);
    run_op("ror36", 2'b11, 32'h0000_00F1, 32'd36, 0);

    // Reset during the third SHIFT cycle of SLL by 20.
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.operand  = 32'h0000_0003;
    bus.amount   = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midshift_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", bus.in_ready, 1);
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_result", bus.result, 0);
    check("midreset_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset", 2'b00, 32'h0000_0003, 32'd20, 1);

    for (int k = 0; k < 150; k++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       r_amt = 32'd0;
        1:       r_amt = $urandom;
        2:       r_amt = 32'd32;
        3:       r_amt = 32'd31;
        4:       r_amt = 32'($urandom_range(32, 100));
        default: r_amt = 32'($urandom_range(1, 31));
      endcase
      run_op($sformatf("rand%0d", k), r_op, $urandom, r_amt, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
